mem_burst_ctrl: RTL and testbench
=================================

# mem_burst_ctrl

Burst command sequencer that sits directly upstream of the single-port memory block. It accepts one burst command at a time (start address, beat count, direction) over a valid/ready handshake. It converts the command into per-beat memory accesses on the memory's `addr`/`wdata`/`wen` port and collects the registered `rdata` into a backpressure-capable read stream. Write data enters and read data leaves through independent valid/ready streams.

## Interface

Parameters:
- `DATA_WIDTH`, default `` `WIDTH ``: data beat width; must match the memory.
- `MEM_DEPTH`, default `` `DEPTH ``: number of memory words; sets the address wrap point.
- `ADDR_WIDTH`, default `` `ADDR_WIDTH ``: memory address width.
- `MAX_LEN`, default 16: maximum beats per burst. Must be a power of two ≥ 2.
- `RESP_DEPTH`, default 2: read response buffer entries. Minimum 2.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `clk`, input, 1: clock.
  - `rst_n`, input, 1: asynchronous active-low reset.
- Command channel:
  - `cmd_valid`, input, 1: command present.
  - `cmd_ready`, output, 1: command accepted this cycle.
  - `cmd_write`, input, 1: 1 = write burst, 0 = read burst.
  - `cmd_addr`, input, ADDR_WIDTH: start word address.
  - `cmd_len`, input, $clog2(MAX_LEN): beats minus one.
- Write data channel:
  - `wr_valid`, input, 1: write beat present.
  - `wr_ready`, output, 1: write beat consumed.
  - `wr_data`, input, DATA_WIDTH: write beat.
- Read data channel:
  - `rd_valid`, output, 1: read beat present.
  - `rd_ready`, input, 1: read beat consumed.
  - `rd_data`, output, DATA_WIDTH: read beat.
  - `rd_last`, output, 1: final beat of the burst.
- Memory port:
  - `mem_addr`, output, ADDR_WIDTH: to memory `addr`.
  - `mem_wdata`, output, DATA_WIDTH: to memory `wdata`.
  - `mem_wen`, output, 1: to memory `wen`.
  - `mem_rdata`, input, DATA_WIDTH: from memory `rdata`, registered with 1-cycle latency.
- Status:
  - `busy`, output, 1: state ≠ IDLE.
  - `done`, output, 1: one-cycle pulse at burst completion.
  - `done_err`, output, 1: qualifies `done`; command was rejected.

## Operation

- **FSM states:** IDLE, WRITE, READ, DRAIN, ERR.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid`, latch address and remaining count = `cmd_len`.
  - If `cmd_addr` ≥ MEM_DEPTH, go to ERR; otherwise go to WRITE or READ according to `cmd_write`.
- **WRITE**
  - `wr_ready` = 1.
  - `mem_wen` = `wr_valid`; `mem_wdata` = `wr_data`; `mem_addr` = current address (all combinational).
  - Each handshake advances the address and decrements the count.
  - The last beat transitions to IDLE.
- **READ**
  - Issue a read (drive `mem_addr`, set the pending flag) when `count + pend − pop < RESP_DEPTH`, where `pop` is this cycle's `rd_valid && rd_ready`.
  - The pending flag captures `mem_rdata` into the buffer on the next cycle, tagged with `last`.
  - The last issue transitions to DRAIN.
- **DRAIN**
  - Move to IDLE when the buffer is empty and no read is pending.
- **ERR:** one cycle, then IDLE; no memory access occurs.
- **Address increment:** wraps from MEM_DEPTH−1 to 0.
- **Completion flag:** `done` is registered and pulses in the first IDLE cycle after a burst. `done_err` = 1 only when the pulse is on exit from ERR.
- **`mem_addr` hold:** `mem_addr` holds its last value when no access is issued. `mem_wen` = 0 in every state except WRITE.
- **Command during a burst:** commands presented while `busy` wait; `cmd_ready` = 0.
- **`cmd_len` = 0:** one beat. `cmd_len` = MAX_LEN−1: MAX_LEN beats.
- **Reset values:**
  - `cmd_ready` = 1.
  - `wr_ready`, `rd_valid`, `rd_last`, `mem_wen`, `busy`, `done`, `done_err` = 0.
  - `rd_data`, `mem_addr`, `mem_wdata` = 0.
- **Reset mid-burst:** aborts the burst, flushes the buffer, and discards any pending read.

## Timing

- **Write path:** command handshake at edge 0 → `wr_ready` from cycle 1. A beat is written at the same edge as its `wr_valid && wr_ready` handshake.
- **Read path:** command handshake at edge 0 → first read issued in cycle 1 → `mem_rdata` valid in cycle 2 → `rd_valid` in cycle 3. First-beat latency is 3 cycles.
- **Read throughput:** one beat per cycle while `rd_ready` = 1.
- **Read backpressure:** `rd_valid`/`rd_data`/`rd_last` stay stable until accepted. No beat is lost or duplicated under any `rd_ready` pattern.
- **Completion latency:** `done` pulses one cycle after the final `wr` handshake or the final `rd` handshake. `cmd_ready` = 1 in the same cycle as the pulse.

## Structure

- **Package `mem_burst_pkg`:** state enum `burst_state_e`, `LEN_W` derivation, and a response entry struct `{last, data}`.
- **Sub-module `mem_burst_resp_fifo`:** RESP_DEPTH-entry synchronous FIFO with count output and same-cycle push/pop.

## Test plan

- **Write with stall:** write burst, addr 4, len 3, data A0–A3, `wr_valid` low for 2 cycles before beat 2 → `mem_wen` at addresses 4, 5, 6, 7 only; `done` pulse one cycle after beat A3.
- **Read streaming:** read burst, addr 4, len 3, `rd_ready` = 1 → A0–A3 on cycles 3–6; `rd_last` only with A3.
- **Read backpressure:** same read with `rd_ready` = 0 for cycles 4–8 → at most 2 beats buffered, reads stall, sequence A0–A3 intact.
- **Address wrap:** MEM_DEPTH = 16, write addr 14, len 3 → writes at 14, 15, 0, 1; read-back matches.
- **Out-of-range command:** MEM_DEPTH = 16, `cmd_addr` = 20 → no `mem_wen`, no `rd_valid`; `done` = `done_err` = 1 two cycles after accept.
- **Reset mid-read:** `rst_n` low during beat 2 of a read → all outputs at reset values immediately; the next read burst returns correct data.

Source files
------------

// File: rtl/mem_burst_pkg.sv
// Shared types for the burst sequencer: FSM states, width helper, and the read response entry.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef DEPTH
`define DEPTH 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif

package mem_burst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_ERR
    } burst_state_e;

    localparam int unsigned RESP_DATA_W = `WIDTH;

    typedef struct packed {
        logic                   last;
        logic [RESP_DATA_W-1:0] data;
    } resp_entry_t;

    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len);
    endfunction

endpackage

// File: rtl/mem_burst_resp_fifo.sv
// Small synchronous FIFO buffering read beats; supports push and pop in the same cycle.
module mem_burst_resp_fifo
    import mem_burst_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  resp_entry_t      push_entry,
    input  logic             pop,
    output resp_entry_t      head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    resp_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage and pointers; entries are cleared on reset so the head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst command sequencer: turns one start/len/dir command into per-beat accesses on a
// single-port memory with 1-cycle read latency, streaming read beats out with backpressure.
module mem_burst_ctrl
    import mem_burst_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = `WIDTH,
    parameter int unsigned MEM_DEPTH  = `DEPTH,
    parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
    parameter int unsigned MAX_LEN    = 16,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [ADDR_WIDTH-1:0]      cmd_addr,
    input  logic [$clog2(MAX_LEN)-1:0] cmd_len,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_last,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    output logic                       mem_wen,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic                       busy,
    output logic                       done,
    output logic                       done_err
);

    localparam int unsigned LEN_W = len_w(MAX_LEN);
    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    burst_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [LEN_W-1:0]      remain_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  pend_q;
    logic                  pend_last_q;
    logic                  done_q;
    logic                  done_err_q;
    logic                  issue;
    logic                  wr_hs;
    logic                  pop;
    logic                  last_beat;
    logic [OCC_W-1:0]      occupancy;
    resp_entry_t           push_entry;
    resp_entry_t           head;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    assign last_beat = (remain_q == '0);
    assign pop       = rd_valid && rd_ready;
    assign cmd_ready = (state_q == ST_IDLE);
    assign wr_ready  = (state_q == ST_WRITE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign done_err  = done_err_q;

    // Next state and memory port; mem_addr/mem_wdata hold their last value when idle.
    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        wr_hs     = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = mem_addr_q;
        mem_wdata = wdata_q;
        occupancy = OCC_W'(fifo_count) + OCC_W'(pend_q) - OCC_W'(pop);
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (32'(cmd_addr) >= MEM_DEPTH) begin
                        state_d = ST_ERR;
                    end else if (cmd_write) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                mem_addr  = addr_q;
                mem_wdata = wr_data;
                mem_wen   = wr_valid;
                wr_hs     = wr_valid;
                if (wr_hs && last_beat) begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                // Reserve a buffer slot for every read in flight so no beat can be dropped.
                issue = (occupancy < OCC_W'(RESP_DEPTH));
                if (issue) begin
                    mem_addr = addr_q;
                    if (last_beat) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!pend_q && (fifo_empty || (fifo_count == CNT_W'(1) && pop))) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst address/count, read-pending tag and completion flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            remain_q    <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && cmd_valid) begin
                addr_q   <= cmd_addr;
                remain_q <= LEN_W'(cmd_len);
            end else if (wr_hs || issue) begin
                addr_q   <= addr_inc(addr_q);
                remain_q <= remain_q - LEN_W'(1);
            end
            pend_q      <= issue;
            pend_last_q <= issue && last_beat;
            mem_addr_q  <= mem_addr;
            wdata_q     <= mem_wdata;
            done_q      <= (state_q != ST_IDLE) && (state_d == ST_IDLE);
            done_err_q  <= (state_q == ST_ERR);
        end
    end

    assign push_entry = '{last: pend_last_q, data: RESP_DATA_W'(mem_rdata)};

    mem_burst_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .CNT_W (CNT_W)
    ) u_resp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (pend_q),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign rd_valid = !fifo_empty;
    assign rd_data  = DATA_WIDTH'(head.data);
    assign rd_last  = rd_valid && head.last;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl: randomized bursts checked against a shadow memory and beat-level rules.
module tb_mem_burst_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LW = 4;
    localparam int MD = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wen;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          done;
    logic          done_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [DW-1:0] tb_mem [MD];
    logic [DW-1:0] ref_mem [MD];

    typedef struct {
        int            a;
        logic [DW-1:0] d;
        int            c;
    } wev_t;
    wev_t wq [$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic done_err_v = 1'b0;

    mem_burst_ctrl #(
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (MD),
        .ADDR_WIDTH (AW),
        .MAX_LEN    (16),
        .RESP_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .done_err  (done_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port memory with registered read data.
    always @(posedge clk) begin
        if (mem_wen) tb_mem[mem_addr[3:0]] <= mem_wdata;
        mem_rdata <= tb_mem[mem_addr[3:0]];
    end

    // Log memory writes and completion pulses mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wen) wq.push_back(wev_t'{int'(mem_addr), mem_wdata, cyc});
            if (done) begin
                done_cnt   <= done_cnt + 1;
                done_cyc   <= cyc;
                done_err_v <= done_err;
            end
        end
    end

    task automatic send_cmd(input bit w, input int a, input int l, output int acc, output bit ok);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = AW'(a);
        cmd_len   = LW'(l);
        ok  = 1'b0;
        acc = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok  = 1'b1;
                acc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input int a, input int l, input int mode);
        logic [DW-1:0] d [16];
        int  acc, wbase, dbase, s, n;
        bit  ok, hs;
        wbase = wq.size();
        dbase = done_cnt;
        for (int i = 0; i <= l; i++) d[i] = $urandom;
        send_cmd(1'b1, a, l, acc, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL wr_cmd_accept: got no cmd_ready, need accept"); end
        for (int i = 0; i <= l; i++) begin
            s = (mode == 2 && i == 2) ? 2 : (mode == 1) ? int'($urandom_range(0, 2)) : 0;
            if (s > 0) begin
                wr_valid = 1'b0;
                repeat (s) begin @(posedge clk); #1; end
            end
            wr_valid = 1'b1;
            wr_data  = d[i];
            hs = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (wr_ready) begin hs = 1'b1; break; end
                @(posedge clk); #1;
            end
            n_cmp++;
            if (!hs) begin n_err++; $display("FAIL wr_ready_timeout: beat %0d got no wr_ready", i); end
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (done_cnt > dbase) break;
        end
        n = wq.size() - wbase;
        n_cmp++;
        if (n !== l + 1) begin
            n_err++; $display("FAIL wr_count: got %0d writes, need %0d", n, l + 1);
        end else begin
            for (int i = 0; i <= l; i++) begin
                n_cmp++;
                if (wq[wbase+i].a !== (a + i) % MD || wq[wbase+i].d !== d[i]) begin
                    n_err++;
                    $display("FAIL wr_beat%0d: got addr %0d data %h, need addr %0d data %h",
                             i, wq[wbase+i].a, wq[wbase+i].d, (a + i) % MD, d[i]);
                end
            end
            if (mode == 0) begin
                n_cmp++;
                if (wq[wbase].c !== acc + 1) begin
                    n_err++; $display("FAIL wr_first_cycle: got %0d, need %0d", wq[wbase].c, acc + 1);
                end
            end
            n_cmp++;
            if (done_cnt !== dbase + 1 || done_cyc !== wq[wbase+l].c + 1 || done_err_v !== 1'b0) begin
                n_err++;
                $display("FAIL wr_done: got cnt %0d cyc %0d err %b, need cnt %0d cyc %0d err 0",
                         done_cnt - dbase, done_cyc, done_err_v, 1, wq[wbase+l].c + 1);
            end
        end
        for (int i = 0; i <= l; i++) ref_mem[(a + i) % MD] = d[i];
    endtask

    task automatic do_read(input int a, input int l, input int mode);
        int  acc, dbase, got, last_hs;
        bit  ok, prev_stall;
        logic [DW-1:0] prev_d, exp_d;
        logic prev_l;
        dbase = done_cnt;
        got = 0; last_hs = 0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
        send_cmd(1'b0, a, l, acc, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rd_cmd_accept: got no cmd_ready, need accept"); end
        for (int k = 1; k < 200; k++) begin
            rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : !(k >= 4 && k <= 8);
            @(negedge clk);
            if (prev_stall) begin
                n_cmp++;
                if (rd_valid !== 1'b1 || rd_data !== prev_d || rd_last !== prev_l) begin
                    n_err++;
                    $display("FAIL rd_hold: got v %b d %h l %b, need v 1 d %h l %b",
                             rd_valid, rd_data, rd_last, prev_d, prev_l);
                end
            end
            if (rd_valid && rd_ready) begin
                exp_d = ref_mem[(a + got) % MD];
                n_cmp++;
                if (rd_data !== exp_d || rd_last !== (got == l)) begin
                    n_err++;
                    $display("FAIL rd_beat%0d: got d %h l %b, need d %h l %b",
                             got, rd_data, rd_last, exp_d, got == l);
                end
                if (mode == 0) begin
                    n_cmp++;
                    if (cyc !== acc + 3 + got) begin
                        n_err++; $display("FAIL rd_beat%0d_cycle: got %0d, need %0d", got, cyc, acc + 3 + got);
                    end
                end
                got++;
                last_hs = cyc;
            end
            prev_stall = rd_valid && !rd_ready;
            prev_d = rd_data;
            prev_l = rd_last;
            if (got == l + 1) break;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (got !== l + 1) begin n_err++; $display("FAIL rd_count: got %0d beats, need %0d", got, l + 1); end
        @(posedge clk); #1;
        rd_ready = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (done_cnt !== dbase + 1 || done_cyc !== last_hs + 1 || done_err_v !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rd_done: got cnt %0d cyc %0d err %b rdy %b, need cnt 1 cyc %0d err 0 rdy 1",
                     done_cnt - dbase, done_cyc, done_err_v, cmd_ready, last_hs + 1);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, wr_ready, rd_valid, rd_last, mem_wen, busy, done, done_err} !== 8'b1000_0000) begin
            n_err++; $display("FAIL reset_ctrl: got %b, need 10000000",
                              {cmd_ready, wr_ready, rd_valid, rd_last, mem_wen, busy, done, done_err});
        end
        n_cmp++;
        if (rd_data !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            n_err++; $display("FAIL reset_data: got %h %h %h, need zeros", rd_data, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, busy, done} !== 3'b100) begin
            n_err++; $display("FAIL reset_release: got %b, need 100", {cmd_ready, busy, done});
        end
    endtask

    task automatic test_max_len;       do_write(0, 15, 1); do_read(0, 15, 0); endtask
    task automatic test_write_stall;   do_write(4, 3, 2); endtask
    task automatic test_read_stream;   do_read(4, 3, 0); endtask
    task automatic test_read_backpressure; do_read(4, 3, 2); endtask
    task automatic test_wrap;          do_write(14, 3, 0); do_read(14, 3, 0); endtask
    task automatic test_len0;          do_write(9, 0, 0); do_read(9, 0, 0); do_read(15, 0, 1); endtask

    task automatic test_err;
        int acc, wbase;
        bit ok;
        wbase = wq.size();
        wr_valid = 1'b1;
        wr_data  = $urandom;
        send_cmd(1'b1, 20, 3, acc, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL err_accept: got no cmd_ready, need accept"); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({mem_wen, rd_valid} !== 2'b00) begin
                n_err++; $display("FAIL err_access%0d: got wen/rv %b, need 00", k, {mem_wen, rd_valid});
            end
            if (k == 1) begin
                n_cmp++;
                if ({busy, cmd_ready, done} !== 3'b100) begin
                    n_err++; $display("FAIL err_busy: got %b, need 100", {busy, cmd_ready, done});
                end
            end
            if (k == 2) begin
                n_cmp++;
                if ({done, done_err, cmd_ready} !== 3'b111) begin
                    n_err++; $display("FAIL err_done: got %b, need 111", {done, done_err, cmd_ready});
                end
            end
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        n_cmp++;
        if (wq.size() !== wbase) begin
            n_err++; $display("FAIL err_nowrite: got %0d writes, need 0", wq.size() - wbase);
        end
    endtask

    task automatic test_reset_mid_read;
        int  acc, got;
        bit  ok;
        got = 0;
        send_cmd(1'b0, 2, 7, acc, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rst_cmd_accept: got no cmd_ready, need accept"); end
        for (int k = 0; k < 50; k++) begin
            rd_ready = 1'b1;
            @(negedge clk);
            if (rd_valid && rd_ready) begin
                n_cmp++;
                if (rd_data !== ref_mem[(2 + got) % MD]) begin
                    n_err++; $display("FAIL rst_pre_beat%0d: got %h, need %h", got, rd_data, ref_mem[(2 + got) % MD]);
                end
                got++;
                if (got == 2) break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        rd_ready = 1'b0;
        #1;
        n_cmp++;
        if ({cmd_ready, wr_ready, rd_valid, rd_last, mem_wen, busy, done, done_err} !== 8'b1000_0000) begin
            n_err++; $display("FAIL rst_mid_ctrl: got %b, need 10000000",
                              {cmd_ready, wr_ready, rd_valid, rd_last, mem_wen, busy, done, done_err});
        end
        n_cmp++;
        if (rd_data !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            n_err++; $display("FAIL rst_mid_data: got %h %h %h, need zeros", rd_data, mem_addr, mem_wdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_read(2, 7, 0);
    endtask

    task automatic test_random;
        int a, l;
        for (int it = 0; it < 12; it++) begin
            a = int'($urandom_range(0, MD - 1));
            l = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) do_write(a, l, int'($urandom_range(0, 1)));
            else do_read(a, l, 1);
        end
    endtask

    initial begin
        test_reset;
        test_max_len;
        test_write_stall;
        test_read_stream;
        test_read_backpressure;
        test_wrap;
        test_len0;
        test_err;
        test_reset_mid_read;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
